// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// byte-enable patterns and op classification helpers.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/half lane out of the
// read word and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_op)
      OP_LW:  o_data = i_rdata;
      OP_LH:  o_data = {{16{w_half[15]}}, w_half};
      OP_LHU: o_data = {16'h0000, w_half};
      OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_data = {24'h000000, w_byte};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage data-access unit: issues one req/ack bus transaction per load/store,
// stalls the pipe while it is outstanding and returns extended load data on M_RD.
// Optional macro ALIGN_CHECK_EN traps misaligned accesses via adel/ades instead of issuing them.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OP_W   = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              pipe_en,
  input  logic              flush,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       M_RD,
  output logic              stall,
  output logic              adel,
  output logic              ades
);

  state_t            r_state;
  logic              r_flush_pend;
  logic [3:0]        r_op;
  logic [1:0]        r_off;
  logic              r_dm_req;
  logic              r_dm_we;
  logic [3:0]        r_dm_be;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [31:0]       r_dm_wdata;
  logic [31:0]       r_rd;

  logic [3:0]  w_op;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic        w_issue;
  logic        w_misalign;

  // Out-of-range codes collapse to NONE so they never start a transaction.
  assign w_op    = (mem_op <= OP_W'(OP_SB)) ? mem_op[3:0] : OP_NONE;
  assign w_off   = addr[1:0];
  assign w_issue = op_valid && (w_op != OP_NONE) && !flush;
  assign stall   = (r_state == ST_REQ) || ((r_state == ST_IDLE) && w_issue);

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = wdata;
    case (w_op)
      OP_SH: begin
        w_be    = w_off[1] ? BE_HALF_HI : BE_HALF_LO;
        w_wdata = {2{wdata[15:0]}};
      end
      OP_SB: begin
        w_be    = BE_BYTE << w_off;
        w_wdata = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata (dm_rdata),
    .i_op    (r_op),
    .i_off   (r_off),
    .o_data  (w_ext)
  );

`ifdef ALIGN_CHECK_EN
  logic r_adel;
  logic r_ades;

  assign w_misalign = (((w_op == OP_LW) || (w_op == OP_SW)) && (w_off != 2'b00)) ||
                      (((w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH)) && w_off[0]);

  // Error flags live exactly as long as the trapped op sits in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_issue && w_misalign) begin
      r_adel <= is_load(w_op);
      r_ades <= !is_load(w_op);
    end else if ((r_state == ST_DONE) && (flush || pipe_en)) begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
    end
  end

  assign adel = r_adel;
  assign ades = r_ades;
`else
  assign w_misalign = 1'b0;
  assign adel       = 1'b0;
  assign ades       = 1'b0;
`endif

  // A flush during REQ cannot cancel the bus cycle; it is remembered and the
  // result dropped once the ack arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_flush_pend <= 1'b0;
      r_op         <= OP_NONE;
      r_off        <= 2'b00;
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_be      <= 4'b0000;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_rd         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rd <= '0;
          if (w_issue) begin
            r_op  <= w_op;
            r_off <= w_off;
            if (w_misalign) begin
              r_state <= ST_DONE;
            end else begin
              r_dm_req   <= 1'b1;
              r_dm_we    <= !is_load(w_op);
              r_dm_be    <= w_be;
              r_dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_dm_wdata <= w_wdata;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dm_ack) begin
            r_dm_req     <= 1'b0;
            r_dm_we      <= 1'b0;
            r_flush_pend <= 1'b0;
            if (r_flush_pend || flush) begin
              r_rd    <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_rd    <= is_load(r_op) ? w_ext : 32'h0;
              r_state <= ST_DONE;
            end
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          if (flush || pipe_en) begin
            r_rd    <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dm_req   = r_dm_req;
  assign dm_we    = r_dm_we;
  assign dm_be    = r_dm_be;
  assign dm_addr  = r_dm_addr;
  assign dm_wdata = r_dm_wdata;
  assign M_RD     = r_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// load/store traffic compared against a lane-arithmetic reference model.
module tb_mem_access_stage;

  localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
  localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

  logic        clk, reset, op_valid, pipe_en, flush, dm_ack;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, dm_rdata;
  logic        dm_req, dm_we, stall, adel, ades;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, M_RD;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.ADDR_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .pipe_en(pipe_en), .flush(flush), .dm_req(dm_req), .dm_we(dm_we),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .M_RD(M_RD), .stall(stall), .adel(adel), .ades(ades)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: little-endian lanes computed with shifts and masks.
  function automatic logic is_ld(input logic [3:0] op);
    return (op >= LW) && (op <= LBU);
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r);
    int unsigned o = a % 4;
    logic [31:0] v;
    case (op)
      LW: return r;
      LH, LHU: begin
        v = (r >> (16 * (o / 2))) & 32'h0000FFFF;
        if (op == LH && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
      end
      LB, LBU: begin
        v = (r >> (8 * o)) & 32'h000000FF;
        if (op == LB && v >= 32'h80) v = v + 32'hFFFFFF00;
        return v;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] a);
    int unsigned o = a % 4;
    if (op == SH) return (o >= 2) ? 4'hC : 4'h3;
    if (op == SB) return 4'(1 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] op, input logic [31:0] w);
    if (op == SH) return (w & 32'h0000FFFF) * 32'h00010001;
    if (op == SB) return (w & 32'h000000FF) * 32'h01010101;
    return w;
  endfunction

  // Runs one op from the cycle sync point through DONE and back to IDLE, recording what it saw.
  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] r, input int waits, input int hold,
                          output logic o_req, output logic o_we, output logic [3:0] o_be,
                          output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output int o_stalls, output logic [31:0] o_rd, output logic o_stable,
                          output logic o_req_done, output logic [31:0] o_rd_after);
    op_valid = 1'b1; mem_op = op; addr = a; wdata = w; pipe_en = 1'b0; flush = 1'b0; dm_ack = 1'b0;
    o_stalls = 0;
    #1;
    if (stall) o_stalls++;
    @(posedge clk); #1;
    o_req = dm_req; o_we = dm_we; o_be = dm_be; o_addr = dm_addr; o_wdata = dm_wdata;
    for (int k = 0; k <= waits; k++) begin
      if (stall) o_stalls++;
      dm_ack   = (k == waits);
      dm_rdata = (k == waits) ? r : $urandom;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0; op_valid = 1'b0;
    #1;
    if (stall) o_stalls++;
    o_req_done = dm_req;
    o_rd = M_RD;
    o_stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (M_RD !== o_rd || stall !== 1'b0) o_stable = 1'b0;
    end
    pipe_en = 1'b1;
    @(posedge clk); #1;
    pipe_en = 1'b0;
    o_rd_after = M_RD;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; mem_op = 4'd0; addr = '0; wdata = '0;
    pipe_en = 1'b0; flush = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    #3;
    total += 8;
    if (dm_req !== 1'b0)     begin bad++; $display("[TB] FAIL rst_req: got %b expected 0", dm_req); end
    if (dm_we !== 1'b0)      begin bad++; $display("[TB] FAIL rst_we: got %b expected 0", dm_we); end
    if (dm_be !== 4'h0)      begin bad++; $display("[TB] FAIL rst_be: got %h expected 0", dm_be); end
    if (dm_addr !== 32'h0)   begin bad++; $display("[TB] FAIL rst_addr: got %h expected 0", dm_addr); end
    if (dm_wdata !== 32'h0)  begin bad++; $display("[TB] FAIL rst_wdata: got %h expected 0", dm_wdata); end
    if (M_RD !== 32'h0)      begin bad++; $display("[TB] FAIL rst_mrd: got %h expected 0", M_RD); end
    if (stall !== 1'b0)      begin bad++; $display("[TB] FAIL rst_stall: got %b expected 0", stall); end
    if ({adel, ades} !== 2'b00) begin bad++; $display("[TB] FAIL rst_flags: got %b expected 00", {adel, ades}); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_directed();
    logic q, we, qd, st; logic [3:0] be; logic [31:0] ad, wd, rd, ra; int ns;
    drive_op(LW, 32'h104, 32'h0, 32'hDEADBEEF, 2, 0, q, we, be, ad, wd, ns, rd, st, qd, ra);
    total += 7;
    if (q !== 1'b1)          begin bad++; $display("[TB] FAIL lw_req: got %b expected 1", q); end
    if (we !== 1'b0)         begin bad++; $display("[TB] FAIL lw_we: got %b expected 0", we); end
    if (be !== 4'hF)         begin bad++; $display("[TB] FAIL lw_be: got %h expected f", be); end
    if (ad !== 32'h104)      begin bad++; $display("[TB] FAIL lw_addr: got %h expected 104", ad); end
    if (ns != 4)             begin bad++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 4", ns); end
    if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lw_mrd: got %h expected deadbeef", rd); end
    if (ra !== 32'h0)        begin bad++; $display("[TB] FAIL lw_mrd_after: got %h expected 0", ra); end
  endtask

  task automatic test_lb_lbu();
    logic q, we, qd, st; logic [3:0] be; logic [31:0] ad, wd, rd, ra; int ns;
    drive_op(LB, 32'h203, 32'h0, 32'h80FF1234, 0, 0, q, we, be, ad, wd, ns, rd, st, qd, ra);
    total += 3;
    if (rd !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL lb_mrd: got %h expected ffffff80", rd); end
    if (ad !== 32'h200)      begin bad++; $display("[TB] FAIL lb_addr: got %h expected 200", ad); end
    if (be !== 4'hF)         begin bad++; $display("[TB] FAIL lb_be: got %h expected f", be); end
    drive_op(LBU, 32'h203, 32'h0, 32'h80FF1234, 1, 0, q, we, be, ad, wd, ns, rd, st, qd, ra);
    total += 1;
    if (rd !== 32'h00000080) begin bad++; $display("[TB] FAIL lbu_mrd: got %h expected 00000080", rd); end
  endtask

  task automatic test_sh();
    logic q, we, qd, st; logic [3:0] be; logic [31:0] ad, wd, rd, ra; int ns;
    drive_op(SH, 32'h302, 32'h0000ABCD, 32'h5A5A5A5A, 1, 0, q, we, be, ad, wd, ns, rd, st, qd, ra);
    total += 5;
    if (we !== 1'b1)         begin bad++; $display("[TB] FAIL sh_we: got %b expected 1", we); end
    if (be !== 4'hC)         begin bad++; $display("[TB] FAIL sh_be: got %h expected c", be); end
    if (wd !== 32'hABCDABCD) begin bad++; $display("[TB] FAIL sh_wdata: got %h expected abcdabcd", wd); end
    if (ad !== 32'h300)      begin bad++; $display("[TB] FAIL sh_addr: got %h expected 300", ad); end
    if (rd !== 32'h0)        begin bad++; $display("[TB] FAIL sh_mrd: got %h expected 0", rd); end
  endtask

  task automatic test_done_hold();
    logic q, we, qd, st; logic [3:0] be; logic [31:0] ad, wd, rd, ra; int ns;
    drive_op(LW, 32'h10, 32'h0, 32'h13572468, 0, 3, q, we, be, ad, wd, ns, rd, st, qd, ra);
    total += 5;
    if (ns != 2)             begin bad++; $display("[TB] FAIL hold_stall_cycles: got %0d expected 2", ns); end
    if (qd !== 1'b0)         begin bad++; $display("[TB] FAIL hold_req_done: got %b expected 0", qd); end
    if (rd !== 32'h13572468) begin bad++; $display("[TB] FAIL hold_mrd: got %h expected 13572468", rd); end
    if (st !== 1'b1)         begin bad++; $display("[TB] FAIL hold_stable: got %b expected 1", st); end
    if (ra !== 32'h0)        begin bad++; $display("[TB] FAIL hold_mrd_after: got %h expected 0", ra); end
  endtask

  task automatic test_nonmem();
    for (int c = 0; c < 16; c++) begin
      if (c >= 1 && c <= 8) continue;
      op_valid = 1'b1; mem_op = 4'(c); addr = $urandom; flush = 1'b0;
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("[TB] FAIL nonmem_stall op=%0d: got %b expected 0", c, stall); end
      @(posedge clk); #1;
      total++;
      if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL nonmem_req op=%0d: got %b expected 0", c, dm_req); end
    end
    mem_op = LW; flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL idle_flush_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    total++;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_flush_req: got %b expected 0", dm_req); end
    op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_flush_req();
    op_valid = 1'b1; mem_op = LW; addr = 32'h40; pipe_en = 1'b0; dm_ack = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    total += 3;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL flush_req_drop: got %b expected 0", dm_req); end
    if (M_RD !== 32'h0)  begin bad++; $display("[TB] FAIL flush_mrd: got %h expected 0", M_RD); end
    if (stall !== 1'b0)  begin bad++; $display("[TB] FAIL flush_stall: got %b expected 0", stall); end
    op_valid = 1'b1; mem_op = LW; addr = 32'h80;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("[TB] FAIL flush_idle_issue: got %b expected 1", stall); end
    @(posedge clk); #1;
    total++;
    if (dm_req !== 1'b1) begin bad++; $display("[TB] FAIL flush_next_req: got %b expected 1", dm_req); end
    dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dm_ack = 1'b0; op_valid = 1'b0;
    total++;
    if (M_RD !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL flush_next_mrd: got %h expected cafef00d", M_RD); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (M_RD !== 32'h0) begin bad++; $display("[TB] FAIL done_flush_mrd: got %h expected 0", M_RD); end
  endtask

  task automatic test_reset_mid_req();
    op_valid = 1'b1; mem_op = LW; addr = 32'h500; dm_ack = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total++;
    if (dm_req !== 1'b1) begin bad++; $display("[TB] FAIL rstreq_pre: got %b expected 1", dm_req); end
    #2 reset = 1'b1;
    #1;
    total += 2;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL rstreq_drop: got %b expected 0", dm_req); end
    if (stall !== 1'b0)  begin bad++; $display("[TB] FAIL rstreq_stall: got %b expected 0", stall); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL rstreq_after: got %b expected 0", dm_req); end
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align();
    op_valid = 1'b1; mem_op = SW; addr = 32'h101; wdata = 32'h11223344; pipe_en = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total += 4;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL align_sw_req: got %b expected 0", dm_req); end
    if ({adel, ades} !== 2'b01) begin bad++; $display("[TB] FAIL align_sw_flags: got %b expected 01", {adel, ades}); end
    if (stall !== 1'b0)  begin bad++; $display("[TB] FAIL align_sw_stall: got %b expected 0", stall); end
    if (M_RD !== 32'h0)  begin bad++; $display("[TB] FAIL align_sw_mrd: got %h expected 0", M_RD); end
    @(posedge clk); #1;
    total++;
    if (ades !== 1'b1) begin bad++; $display("[TB] FAIL align_sw_hold: got %b expected 1", ades); end
    pipe_en = 1'b1;
    @(posedge clk); #1;
    pipe_en = 1'b0;
    total++;
    if (ades !== 1'b0) begin bad++; $display("[TB] FAIL align_sw_clear: got %b expected 0", ades); end
    op_valid = 1'b1; mem_op = LH; addr = 32'h201;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total += 2;
    if (dm_req !== 1'b0) begin bad++; $display("[TB] FAIL align_lh_req: got %b expected 0", dm_req); end
    if ({adel, ades} !== 2'b10) begin bad++; $display("[TB] FAIL align_lh_flags: got %b expected 10", {adel, ades}); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (adel !== 1'b0) begin bad++; $display("[TB] FAIL align_lh_clear: got %b expected 0", adel); end
  endtask
`endif

  task automatic test_back_to_back();
    logic q, we, qd, st; logic [3:0] be; logic [31:0] ad, wd, rd, ra; int ns;
    logic [3:0] op; logic [31:0] a, w, r; int waits, hold;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8)); a = $urandom; w = $urandom; r = $urandom;
      waits = $urandom_range(0, 3); hold = $urandom_range(0, 2);
`ifdef ALIGN_CHECK_EN
      if (op == LW || op == SW) a = a & 32'hFFFFFFFC;
      if (op == LH || op == LHU || op == SH) a = a & 32'hFFFFFFFE;
`endif
      drive_op(op, a, w, r, waits, hold, q, we, be, ad, wd, ns, rd, st, qd, ra);
      total += 9;
      if (q !== 1'b1)                 begin bad++; $display("[TB] FAIL rnd%0d_req: got %b expected 1", i, q); end
      if (we !== !is_ld(op))          begin bad++; $display("[TB] FAIL rnd%0d_we op=%0d: got %b expected %b", i, op, we, !is_ld(op)); end
      if (be !== model_be(op, a))     begin bad++; $display("[TB] FAIL rnd%0d_be op=%0d: got %h expected %h", i, op, be, model_be(op, a)); end
      if (ad !== (a & 32'hFFFFFFFC))  begin bad++; $display("[TB] FAIL rnd%0d_addr: got %h expected %h", i, ad, a & 32'hFFFFFFFC); end
      if (!is_ld(op) && wd !== model_wd(op, w)) begin bad++; $display("[TB] FAIL rnd%0d_wdata op=%0d: got %h expected %h", i, op, wd, model_wd(op, w)); end
      if (ns != 2 + waits)            begin bad++; $display("[TB] FAIL rnd%0d_stall_cycles: got %0d expected %0d", i, ns, 2 + waits); end
      if (rd !== model_rd(op, a, r))  begin bad++; $display("[TB] FAIL rnd%0d_mrd op=%0d a=%h: got %h expected %h", i, op, a, rd, model_rd(op, a, r)); end
      if (st !== 1'b1 || qd !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_done: got stable=%b req=%b expected 1 0", i, st, qd); end
      if (ra !== 32'h0)               begin bad++; $display("[TB] FAIL rnd%0d_mrd_after: got %h expected 0", i, ra); end
    end
  endtask

  initial begin
    test_reset();
    test_lw_directed();
    test_lb_lbu();
    test_sh();
    test_done_hold();
    test_nonmem();
    test_flush_req();
    test_reset_mid_req();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage data-access unit in the five-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes a decoded load/store op with address and store data. Drives a request/acknowledge data-memory bus, generates byte enables, and returns sign- or zero-extended load data as M_RD.
- Raises a stall to hold the pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width. Bits [1:0] are the byte offset.
- OP_W, 4, width of the mem_op encoding.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  M-stage holds a valid instruction
- mem_op  in  OP_W  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; codes 9-15 behave as NONE
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rt value)
- pipe_en  in  1  downstream pipeline advances this edge
- flush  in  1  discard the current M-stage instruction
- dm_req  out  1  bus request, registered
- dm_we  out  1  write strobe, registered
- dm_be  out  4  byte enables, registered
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits 0), registered
- dm_wdata  out  32  lane-replicated store data, registered
- dm_ack  in  1  bus completes the transaction this cycle
- dm_rdata  in  32  read word, valid when dm_ack=1
- M_RD  out  32  extended load data; 0 for stores and NONE
- stall  out  1  combinational; holds upstream and MW enable low
- adel  out  1  load address error (ALIGN_CHECK_EN only)
- ades  out  1  store address error (ALIGN_CHECK_EN only)

Behaviour:
- Reset (asynchronous): state=IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, M_RD=0, adel=0, ades=0, flush_pend=0.
- Upstream holds op_valid, mem_op, addr and wdata stable while stall=1.

State machine:
- IDLE:
  - If op_valid, mem_op is a memory op and flush=0: latch the dm_* outputs, set dm_req<=1, go to REQ. stall=1 in this cycle.
  - Otherwise (non-memory op, or flush): stall=0, M_RD=0, stay in IDLE.
- REQ:
  - dm_req, dm_we, dm_be, dm_addr and dm_wdata are held constant. stall=1.
  - Edge with dm_ack=1: dm_req<=0, dm_we<=0. If a load, M_RD<=extend(dm_rdata). Go to DONE.
  - If flush was seen during REQ (or arrives in the ack cycle): flush_pend is set. The transaction still completes, but the result is discarded: M_RD<=0, go to IDLE.
- DONE:
  - stall=0, M_RD valid.
  - pipe_en=1: go to IDLE and clear M_RD to 0 on that edge. pipe_en=0: hold DONE and M_RD.
  - flush in DONE: go to IDLE with M_RD=0.

Timing:
- Minimum occupancy is 3 cycles per memory op (IDLE issue, REQ with same-cycle ack, DONE).
- Each additional ack wait cycle adds 1 cycle.

Byte enables and store lanes (little-endian, o = addr[1:0]):
- SW: be=1111.
- SH: be=0011 if o[1]=0, else 1100; wdata[15:0] is replicated to both halves.
- SB: be=0001<<o; wdata[7:0] is replicated to all four lanes.
- Loads: be=1111, dm_we=0.

Load extension:
- LB/LBU: byte lane o, sign- or zero-extended.
- LH/LHU: half lane o[1], sign- or zero-extended.
- LW: whole word.

Misalignment with the feature off:
- Offending low bits are ignored: a word access uses o=00, a half access uses o[0]=0.

Other rules:
- Reset asserted in REQ abandons the transaction immediately; dm_req drops asynchronously.
- Only one transaction is outstanding at a time; no new request is issued until the state returns to IDLE.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - A misaligned access never issues a bus request. Misaligned means LW/SW with o≠00, or LH/LHU/SH with o[0]=1.
  - The op goes IDLE→DONE in 1 cycle with M_RD=0, and adel (loads) or ades (stores) =1 for as long as DONE holds.
  - Both flags clear on leaving DONE.
- Undefined: adel and ades are tied to 0 and the ignore-low-bits rule applies.

Decomposition:
- Shared package mem_pkg holds:
  - mem_op code constants (OP_NONE..OP_SB);
  - state encoding (ST_IDLE, ST_REQ, ST_DONE);
  - byte-enable constants (BE_WORD, BE_HALF_LO, BE_HALF_HI);
  - helper function is_load.
- One natural sub-module: load_extend. It is combinational: lane select plus sign/zero extension from dm_rdata, mem_op and offset.

Test Plan:
- LW addr=0x104, dm_rdata=0xDEADBEEF, ack 2 cycles after req → dm_addr=0x104, be=1111, stall=1 for 4 cycles, M_RD=0xDEADBEEF in DONE.
- LB addr=0x203, rdata=0x80FF1234 → M_RD=0xFFFFFF80; LBU with the same inputs → M_RD=0x00000080.
- SH addr=0x302, wdata=0x0000ABCD → dm_we=1, be=1100, dm_wdata=0xABCDABCD, dm_addr=0x300, M_RD=0.
- LW with ack, then pipe_en=0 for 3 cycles → DONE held, stall=0, M_RD stable; pipe_en=1 → IDLE, M_RD=0.
- Flush in REQ cycle 1, ack in cycle 3 → dm_req drops on the ack edge, state IDLE, M_RD=0, no DONE cycle.
- reset mid-REQ → dm_req=0 and state=IDLE immediately. With ALIGN_CHECK_EN: SW addr=0x101 → no dm_req, ades=1 in DONE.
